// File: rtl/alu_seq_if.sv
// alu_seq handshake and operand/result bundle.
// Control unit drives master; the ALU implements slave.
interface alu_seq_if #(
  parameter int WORD_SIZE = 16,
  parameter int OP_SIZE   = 4
);
  logic                 start;
  logic [OP_SIZE-1:0]   sel;
  logic [WORD_SIZE-1:0] data_1;
  logic [WORD_SIZE-1:0] data_2;
  logic                 busy;
  logic                 done;
  logic [WORD_SIZE-1:0] alu_out;
  logic [WORD_SIZE-1:0] hi_out;
  logic                 alu_zero_flag;
  logic                 ovf_flag;
  logic                 div_zero;

  modport master (
    output start, sel, data_1, data_2,
    input  busy, done, alu_out, hi_out,
    input  alu_zero_flag, ovf_flag, div_zero
  );

  modport slave (
    input  start, sel, data_1, data_2,
    output busy, done, alu_out, hi_out,
    output alu_zero_flag, ovf_flag, div_zero
  );
endinterface

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with iterative unsigned MUL/DIV.
// Results load on entry to FIN so they are valid while done is high.
module alu_seq #(
  parameter int WORD_SIZE = 16,
  parameter int OP_SIZE   = 4,
  parameter int CNT_W     = 5
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int W = WORD_SIZE;

  localparam logic [OP_SIZE-1:0] OP_AND  = OP_SIZE'(4'b0101);
  localparam logic [OP_SIZE-1:0] OP_OR   = OP_SIZE'(4'b0110);
  localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(4'b0111);
  localparam logic [OP_SIZE-1:0] OP_SUB  = OP_SIZE'(4'b1000);
  localparam logic [OP_SIZE-1:0] OP_SLT  = OP_SIZE'(4'b1001);
  localparam logic [OP_SIZE-1:0] OP_MUL  = OP_SIZE'(4'b1101);
  localparam logic [OP_SIZE-1:0] OP_DIV  = OP_SIZE'(4'b1110);
  localparam logic [OP_SIZE-1:0] OP_SLTU = OP_SIZE'(4'b1111);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OP_SIZE-1:0] op_q, op_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic [2*W-1:0]     acc_q, acc_d;
  logic [W:0]         rem_q, rem_d;
  logic [W-1:0]       out_q, out_d, hi_q, hi_d;
  logic               ovf_q, ovf_d, dz_q, dz_d;

  logic [W-1:0] s_out, s_hi, sum, dif;
  logic         s_ovf, s_dz;
  logic [W:0]   mul_sum;
  logic [2*W-1:0] mul_acc;
  logic [W:0]   div_sh, div_tr, div_rem;
  logic [W-1:0] div_quo;
  logic         long_op;

  // single-cycle results straight from the operand inputs
  always_comb begin
    s_out = '0;
    s_hi  = '0;
    s_ovf = 1'b0;
    s_dz  = 1'b0;
    sum   = bus.data_1 + bus.data_2;
    dif   = bus.data_1 - bus.data_2;
    case (bus.sel)
      OP_AND: s_out = bus.data_1 & bus.data_2;
      OP_OR:  s_out = bus.data_1 | bus.data_2;
      OP_ADD: begin
        s_out = sum;
        s_ovf = (bus.data_1[W-1] == bus.data_2[W-1]) &&
                (sum[W-1] != bus.data_1[W-1]);
      end
      OP_SUB: begin
        s_out = dif;
        s_ovf = (bus.data_1[W-1] != bus.data_2[W-1]) &&
                (dif[W-1] != bus.data_1[W-1]);
      end
      OP_SLT:
        s_out = {{(W-1){1'b0}},
                 $signed(bus.data_1) < $signed(bus.data_2)};
      OP_SLTU:
        s_out = {{(W-1){1'b0}}, bus.data_1 < bus.data_2};
      OP_DIV: begin
        s_out = '1;
        s_hi  = bus.data_1;
        s_dz  = 1'b1;
      end
      default: ;
    endcase
  end

  // one shift-add step and one restoring-divide step
  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, a_q};
    if (acc_q[0]) mul_acc = {mul_sum, acc_q[W-1:1]};
    else          mul_acc = {1'b0, acc_q[2*W-1:1]};
    div_sh = {rem_q[W-1:0], acc_q[W-1]};
    div_tr = div_sh - {1'b0, b_q};
    if (div_tr[W]) begin
      div_rem = div_sh;
      div_quo = {acc_q[W-2:0], 1'b0};
    end else begin
      div_rem = div_tr;
      div_quo = {acc_q[W-2:0], 1'b1};
    end
  end

  assign long_op = (bus.sel == OP_MUL) ||
                   ((bus.sel == OP_DIV) && (bus.data_2 != '0));

  // next-state, datapath and result loading
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    out_d   = out_q;
    hi_d    = hi_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (bus.start) begin
        op_d = bus.sel;
        a_d  = bus.data_1;
        b_d  = bus.data_2;
        if (long_op) begin
          state_d = RUN;
          cnt_d   = '0;
          rem_d   = '0;
          if (bus.sel == OP_MUL) acc_d = {{W{1'b0}}, bus.data_2};
          else                   acc_d = {{W{1'b0}}, bus.data_1};
        end else begin
          state_d = FIN;
          out_d   = s_out;
          hi_d    = s_hi;
          ovf_d   = s_ovf;
          dz_d    = s_dz;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          acc_d = mul_acc;
        end else begin
          acc_d = {{W{1'b0}}, div_quo};
          rem_d = div_rem;
        end
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = FIN;
          dz_d    = 1'b0;
          if (op_q == OP_MUL) begin
            out_d = mul_acc[W-1:0];
            hi_d  = mul_acc[2*W-1:W];
            ovf_d = (mul_acc[2*W-1:W] != '0);
          end else begin
            out_d = div_quo;
            hi_d  = div_rem[W-1:0];
            ovf_d = 1'b0;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      hi_q    <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == FIN);
  assign bus.alu_out       = out_q;
  assign bus.hi_out        = hi_q;
  assign bus.alu_zero_flag = (out_q == '0);
  assign bus.ovf_flag      = ovf_q;
  assign bus.div_zero      = dz_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: random and directed ops
// checked against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 16;

  localparam logic [3:0] AND_ = 4'b0101;
  localparam logic [3:0] OR_  = 4'b0110;
  localparam logic [3:0] ADD_ = 4'b0111;
  localparam logic [3:0] SUB_ = 4'b1000;
  localparam logic [3:0] SLT_ = 4'b1001;
  localparam logic [3:0] MUL_ = 4'b1101;
  localparam logic [3:0] DIV_ = 4'b1110;
  localparam logic [3:0] SLTU_ = 4'b1111;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] out;
    logic [15:0] hi;
    logic        z;
    logic        ovf;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  alu_seq_if #(.WORD_SIZE(W), .OP_SIZE(4)) bus ();

  alu_seq #(.WORD_SIZE(W), .OP_SIZE(4), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t e;
    int s;
    longint p;
    e.op = op; e.out = 16'h0; e.hi = 16'h0;
    e.ovf = 1'b0; e.dz = 1'b0; e.lat = 1; e.acc = 0;
    case (op)
      AND_: e.out = a & b;
      OR_:  e.out = a | b;
      ADD_: begin
        s = int'($signed(a)) + int'($signed(b));
        e.out = s[15:0];
        e.ovf = (s > 32767) || (s < -32768);
      end
      SUB_: begin
        s = int'($signed(a)) - int'($signed(b));
        e.out = s[15:0];
        e.ovf = (s > 32767) || (s < -32768);
      end
      SLT_:  e.out = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      SLTU_: e.out = (a < b) ? 16'd1 : 16'd0;
      MUL_: begin
        p = longint'(a) * longint'(b);
        e.out = p[15:0];
        e.hi  = p[31:16];
        e.ovf = (e.hi != 0);
        e.lat = W + 1;
      end
      DIV_: begin
        if (b == 0) begin
          e.out = 16'hFFFF;
          e.hi  = a;
          e.dz  = 1'b1;
        end else begin
          e.out = a / b;
          e.hi  = a % b;
          e.lat = W + 1;
        end
      end
      default: ;
    endcase
    e.z = (e.out == 0);
    return e;
  endfunction

  // monitor: pop and compare on every done pulse
  always @(negedge clk) begin
    exp_t e;
    int lat;
    if (!rst && bus.done) begin
      total++;
      if (!bus.busy) begin
        bad++;
        $display("FAIL busy_at_done busy=%0b want 1", bus.busy);
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done out=%h nothing queued",
                 bus.alu_out);
      end else begin
        e = sb.pop_front();
        if (bus.alu_out !== e.out || bus.hi_out !== e.hi ||
            bus.alu_zero_flag !== e.z || bus.ovf_flag !== e.ovf ||
            bus.div_zero !== e.dz) begin
          bad++;
          $display("FAIL result op=%b got out=%h hi=%h z=%b ovf=%b dz=%b want out=%h hi=%h z=%b ovf=%b dz=%b",
                   e.op, bus.alu_out, bus.hi_out, bus.alu_zero_flag,
                   bus.ovf_flag, bus.div_zero, e.out, e.hi, e.z,
                   e.ovf, e.dz);
        end
        total++;
        lat = cyc - e.acc + 1;
        if (lat != e.lat) begin
          bad++;
          $display("FAIL latency op=%b got %0d want %0d",
                   e.op, lat, e.lat);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op,
                       input logic [15:0] a,
                       input logic [15:0] b);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      total++;
      bad++;
      $display("FAIL busy_timeout busy=%0b want 0", bus.busy);
    end else begin
      bus.start = 1'b1;
      bus.sel = op;
      bus.data_1 = a;
      bus.data_2 = b;
      @(posedge clk);
      #1;
      e = model(op, a, b);
      e.acc = cyc;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!bus.done) begin
      bad++;
      $display("FAIL done_timeout done=%0b want 1", bus.done);
    end
  endtask

  task automatic check_reset(input string tag);
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.alu_out !== 16'h0 || bus.hi_out !== 16'h0 ||
        bus.alu_zero_flag !== 1'b1 || bus.ovf_flag !== 1'b0 ||
        bus.div_zero !== 1'b0) begin
      bad++;
      $display("FAIL %s busy=%b done=%b out=%h hi=%h z=%b ovf=%b dz=%b want 0 0 0000 0000 1 0 0",
               tag, bus.busy, bus.done, bus.alu_out, bus.hi_out,
               bus.alu_zero_flag, bus.ovf_flag, bus.div_zero);
    end
  endtask

  initial begin
    logic [3:0] ops [10];
    logic [15:0] ra, rb;
    int n;
    ops = '{AND_, OR_, ADD_, SUB_, SLT_, MUL_, DIV_, SLTU_,
            4'b0000, 4'b0011};
    bus.start = 1'b0;
    bus.sel = 4'h0;
    bus.data_1 = 16'h0;
    bus.data_2 = 16'h0;
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_reset("after_release");

    issue(ADD_, 16'h7FFF, 16'h0001);
    issue(SUB_, 16'h0005, 16'h0005);
    issue(SLT_, 16'hFFFF, 16'h0001);
    issue(SLTU_, 16'hFFFF, 16'h0001);

    // MUL with an ignored ADD start mid-flight
    issue(MUL_, 16'h1234, 16'h0100);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.sel = ADD_;
    bus.data_1 = 16'h1111;
    bus.data_2 = 16'h2222;
    @(negedge clk);
    bus.start = 1'b0;

    issue(DIV_, 16'd100, 16'd7);
    issue(DIV_, 16'h0042, 16'h0000);
    issue(MUL_, 16'h00FF, 16'h0003);

    // async reset in the middle of a MUL
    issue(MUL_, 16'hFFFF, 16'hFFFF);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("mid_op_reset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(AND_, 16'h0F0F, 16'h00FF);

    // start held in the done cycle must be ignored
    issue(DIV_, 16'hBEEF, 16'h0013);
    @(negedge clk);
    wait_done();
    bus.start = 1'b1;
    bus.sel = AND_;
    bus.data_1 = 16'hFFFF;
    bus.data_2 = 16'hFFFF;
    @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL start_in_done busy=%b want 0", bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b0;

    issue(4'b0000, 16'h1234, 16'h5678);
    issue(ADD_, 16'h8000, 16'hFFFF);
    issue(SUB_, 16'h8000, 16'h0001);
    issue(SUB_, 16'h7FFF, 16'hFFFF);

    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      issue(ops[$urandom_range(0, 9)], ra, rb);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
